mer_calc: RTL

MER_CALC -- requirements
Module: mer_calc

---
 rtl/mer_calc.sv | 106 ++++++++++
 1 files changed

// File: rtl/mer_calc.sv
`default_nettype none
// ============================================================================
// Module      : mer_calc
// Description : Modulation-error-ratio divider. Serial restoring division of
//               clamped decision power by per-symbol squared error.
// Revision    : 1.0 - initial release
// ============================================================================
module mer_calc #(
    parameter int FRAC      = 16,
    parameter int DEN_SHIFT = 20
) (
    input  logic                   sys_clk,
    input  logic                   reset_n,
    input  logic                   cycle,
    input  logic signed [17:0]     map_out_pwr,
    input  logic [55:0]            err_square,
    output logic [18+FRAC-1:0]     mer_ratio,
    output logic                   done,
    output logic                   busy,
    output logic                   div0,
    output logic                   overrun
);

    localparam int QW = 18 + FRAC;
    localparam int DW = 36;
    localparam int CW = $clog2(QW + 1);
    localparam logic [CW-1:0] STEPS = CW'(QW);
    localparam logic [CW-1:0] LAST  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [QW-1:0]   num;
    logic [DW-1:0]   den;
    logic [DW-1:0]   rem;
    logic [CW-1:0]   cnt;

    logic [QW-1:0]   num_in;
    logic [DW-1:0]   den_in;
    logic [DW:0]     rem_sh;
    logic [DW-1:0]   rem_sub;
    logic            ge;

    // Negative power clamps to a zero numerator.
    assign num_in  = map_out_pwr[17] ? '0 : (QW'($unsigned(map_out_pwr)) << FRAC);
    assign den_in  = DW'(err_square >> DEN_SHIFT);

    // When ge holds the true difference is below den, so DW bits suffice.
    assign rem_sh  = {rem, num[QW-1]};
    assign ge      = (rem_sh >= {1'b0, den});
    assign rem_sub = rem_sh[DW-1:0] - den;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            num       <= '0;
            den       <= '0;
            rem       <= '0;
            cnt       <= '0;
            mer_ratio <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            div0      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cycle && (state != IDLE))
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (cycle) begin
                        num   <= num_in;
                        den   <= den_in;
                        rem   <= '0;
                        cnt   <= STEPS;
                        busy  <= 1'b1;
                        state <= DIV;
                    end
                end
                DIV: begin
                    // Quotient bits shift into num as the dividend bits leave it.
                    num <= {num[QW-2:0], ge};
                    rem <= ge ? rem_sub : rem_sh[DW-1:0];
                    cnt <= cnt - LAST;
                    if (cnt == LAST)
                        state <= DONE;
                end
                DONE: begin
                    mer_ratio <= num;
                    div0      <= (den == '0);
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
